// File: rtl/matrix_scan_driver_pkg.sv
// rtl/matrix_scan_driver_pkg.sv - shared constants, state type and frame helpers for the row scanner
//
// Purpose: geometry of the 12x16 display, the scan FSM state encoding and
// helpers that pick a row out of a packed frame. The frame builder in the
// bench uses the same constants, so both sides agree on row ordering.
//
// Contents:
//   ROWS, COLS, FRAME_W  display geometry
//   LAST_ROW             index of the bottom row (frame boundary row)
//   scan_state_e         ST_OFF / ST_BLANK / ST_DRIVE
//   row_slice()          16 column bits of display row r (row 0 = top = MSBs)
//   row_onehot()         one-hot row strobe for row r

package matrix_scan_driver_pkg;

  localparam int ROWS    = 12;
  localparam int COLS    = 16;
  localparam int FRAME_W = ROWS * COLS;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Row 0 lives in the most significant slice of the packed frame.
  function automatic logic [COLS-1:0] row_slice(input logic [FRAME_W-1:0] frame,
                                                input logic [3:0]         row);
    return frame[(ROWS - 1 - int'(row)) * COLS +: COLS];
  endfunction

  function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] row);
    return ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// rtl/matrix_scan_driver_scan_timer.sv - loadable down-counter with terminal-count flags
//
// Purpose: times both the blanking and the drive phase of each row. Loading
// N-1 yields a phase of exactly N cycles: o_tc is high on the last one.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset (count cleared)
//   i_load       load i_load_val this cycle (takes priority over counting)
//   i_load_val   value to load
//   o_tc         count is zero: current cycle is the last of the phase
//   o_tc_next    count will be zero after this edge (look-ahead of o_tc)

module matrix_scan_driver_scan_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc,
  output logic         o_tc_next
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc      = (r_count == '0);
  // Saturating at zero means "next is zero" whenever the count is 0 or 1.
  assign o_tc_next = i_load ? (i_load_val == '0) : (r_count <= W'(1));

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - 12-row multiplexed LED matrix scanner with shadow frame buffer
//
// Purpose: walks rows 0..11, inserting BLANK dark cycles before each row and
// driving the row for DIV cycles. The displayed frame comes from a shadow
// copy that is refreshed only at frame boundaries, so frame_data may change
// at any time without tearing.
//
// Ports:
//   i_clk          system clock, all state changes on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           scan enable; low forces OFF (dark) on the next cycle
//   i_frame_data   12x16 frame, row r at [(11-r)*16 +: 16]
//   i_frame_valid  i_frame_data may be captured at the next frame boundary
//   o_frame_ack    one-cycle pulse: shadow frame has just been loaded
//   o_row_sel      one-hot row strobe (zero while blanking or off)
//   o_col_data     column drive for the selected row (zero unless driving)
//   o_frame_done   one-cycle pulse on the last drive cycle of row 11
//   o_cur_row      row currently being blanked or driven
//
// Timing: every output is a register loaded from the next-state values, so
// outputs line up with the state they describe. The shadow samples
// i_frame_data on the edge that leaves the boundary cycle (row 11's last
// drive cycle, or the OFF cycle in which i_en is seen high); o_frame_ack is
// high during the first cycle that uses the new shadow.

module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [FRAME_W-1:0] i_frame_data,
  input  logic               i_frame_valid,
  output logic               o_frame_ack,
  output logic [ROWS-1:0]    o_row_sel,
  output logic [COLS-1:0]    o_col_data,
  output logic               o_frame_done,
  output logic [3:0]         o_cur_row
);

  localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
  localparam bit               HAS_BLANK  = (BLANK > 0);

  scan_state_e        r_state;
  logic [3:0]         r_row;
  logic [FRAME_W-1:0] r_shadow;
  logic [ROWS-1:0]    r_row_sel;
  logic [COLS-1:0]    r_col_data;
  logic               r_frame_ack;
  logic               r_frame_done;

  scan_state_e        w_state_nxt;
  logic [3:0]         w_row_nxt;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tc;
  logic               w_tc_nxt;
  logic               w_frame_load;
  logic [FRAME_W-1:0] w_shadow_nxt;
  logic               w_done_nxt;

  matrix_scan_driver_scan_timer #(
    .W (CNT_W)
  ) u_scan_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tc),
    .o_tc_next  (w_tc_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_frame_load = 1'b0;

    if (!i_en) begin
      // Disable wins in every state; the timer is held cleared while off.
      w_state_nxt = ST_OFF;
      w_row_nxt   = '0;
      w_tmr_load  = 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_row_nxt    = '0;
          w_tmr_load   = 1'b1;
          w_frame_load = i_frame_valid;
          if (HAS_BLANK) begin
            w_state_nxt = ST_BLANK;
            w_tmr_val   = BLANK_LOAD;
          end else begin
            w_state_nxt = ST_DRIVE;
            w_tmr_val   = DRIVE_LOAD;
          end
        end
        ST_BLANK: begin
          if (w_tc) begin
            w_state_nxt = ST_DRIVE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = DRIVE_LOAD;
          end
        end
        ST_DRIVE: begin
          if (w_tc) begin
            w_tmr_load = 1'b1;
            if (r_row == LAST_ROW) begin
              w_row_nxt    = '0;
              w_frame_load = i_frame_valid;
            end else begin
              w_row_nxt = r_row + 4'd1;
            end
            if (HAS_BLANK) begin
              w_state_nxt = ST_BLANK;
              w_tmr_val   = BLANK_LOAD;
            end else begin
              w_state_nxt = ST_DRIVE;
              w_tmr_val   = DRIVE_LOAD;
            end
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_row_nxt   = '0;
          w_tmr_load  = 1'b1;
        end
      endcase
    end
  end

  // The row entered at a boundary must already show the freshly captured frame.
  assign w_shadow_nxt = w_frame_load ? i_frame_data : r_shadow;

  // Flag the cycle being entered if it is the final drive cycle of row 11.
  assign w_done_nxt = (w_state_nxt == ST_DRIVE) && (w_row_nxt == LAST_ROW) && w_tc_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row        <= '0;
      r_shadow     <= '0;
      r_row_sel    <= '0;
      r_col_data   <= '0;
      r_frame_ack  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_row        <= w_row_nxt;
      r_shadow     <= w_shadow_nxt;
      r_frame_ack  <= w_frame_load;
      r_frame_done <= w_done_nxt;
      if (w_state_nxt == ST_DRIVE) begin
        r_row_sel  <= row_onehot(w_row_nxt);
        r_col_data <= row_slice(w_shadow_nxt, w_row_nxt);
      end else begin
        r_row_sel  <= '0;
        r_col_data <= '0;
      end
    end
  end

  assign o_frame_ack  = r_frame_ack;
  assign o_row_sel    = r_row_sel;
  assign o_col_data   = r_col_data;
  assign o_frame_done = r_frame_done;
  assign o_cur_row    = r_row;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - scoreboard bench for matrix_scan_driver (blanked and unblanked builds)

module tb_matrix_scan_driver;
  import matrix_scan_driver_pkg::*;

  localparam int A_DIV   = 4;
  localparam int A_BLANK = 2;
  localparam int A_PER   = ROWS * (A_DIV + A_BLANK);
  localparam int B_DIV   = 2;
  localparam int B_BLANK = 0;
  localparam int B_PER   = ROWS * (B_DIV + B_BLANK);

  typedef struct packed {
    logic            ack;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col;
    logic            done;
    logic [3:0]      cur_row;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               frame_valid;
  logic [FRAME_W-1:0] frame_data;

  logic               a_ack, a_done, b_ack, b_done;
  logic [ROWS-1:0]    a_row_sel, b_row_sel;
  logic [COLS-1:0]    a_col, b_col;
  logic [3:0]         a_cur_row, b_cur_row;

  obs_t obs_a, obs_b, exp_a, exp_b;
  obs_t q_a[$];
  obs_t q_b[$];

  int n_vec = 0;
  int n_bad = 0;
  bit b_track = 1'b0;

  bit                 a_run = 1'b0, b_run = 1'b0;
  int                 a_pos = 0, b_pos = 0;
  logic [FRAME_W-1:0] a_shadow = '0, b_shadow = '0;

  assign obs_a = {a_ack, a_row_sel, a_col, a_done, a_cur_row};
  assign obs_b = {b_ack, b_row_sel, b_col, b_done, b_cur_row};

  initial forever #5 clk = ~clk;

  matrix_scan_driver #(.DIV(A_DIV), .BLANK(A_BLANK)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_frame_data(frame_data),
    .i_frame_valid(frame_valid), .o_frame_ack(a_ack), .o_row_sel(a_row_sel),
    .o_col_data(a_col), .o_frame_done(a_done), .o_cur_row(a_cur_row)
  );

  matrix_scan_driver #(.DIV(B_DIV), .BLANK(B_BLANK)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_frame_data(frame_data),
    .i_frame_valid(frame_valid), .o_frame_ack(b_ack), .o_row_sel(b_row_sel),
    .o_col_data(b_col), .o_frame_done(b_done), .o_cur_row(b_cur_row)
  );

  // Expected outputs from the position inside the frame counted since OFF exit.
  function automatic obs_t model_out(bit run, int pos, bit ack, logic [FRAME_W-1:0] shadow,
                                     int div, int blank);
    obs_t e;
    int row, ph;
    e = '0;
    e.ack = ack;
    if (run) begin
      row = pos / (div + blank);
      ph  = pos % (div + blank);
      e.cur_row = 4'(row);
      if (ph >= blank) begin
        e.row_sel = ROWS'(1) << row;
        e.col     = shadow[(ROWS - 1 - row) * COLS +: COLS];
        e.done    = (row == ROWS - 1) && (ph == div + blank - 1);
      end
    end
    return e;
  endfunction

  function automatic logic [FRAME_W-1:0] make_frame(logic [15:0] seed);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[(ROWS - 1 - r) * COLS +: COLS] = seed + 16'(r * 273);
    return f;
  endfunction

  initial forever begin
    bit ld;
    @(posedge clk);
    ld = 1'b0;
    if (!rst_n) begin a_run = 1'b0; a_pos = 0; a_shadow = '0; end
    else if (!en) begin a_run = 1'b0; a_pos = 0; end
    else if (!a_run) begin a_run = 1'b1; a_pos = 0; ld = frame_valid; end
    else if (a_pos == A_PER - 1) begin a_pos = 0; ld = frame_valid; end
    else a_pos++;
    if (ld) a_shadow = frame_data;
    q_a.push_back(model_out(a_run, a_pos, ld, a_shadow, A_DIV, A_BLANK));
  end

  initial forever begin
    bit ld;
    @(posedge clk);
    ld = 1'b0;
    if (!rst_n) begin b_run = 1'b0; b_pos = 0; b_shadow = '0; end
    else if (!en) begin b_run = 1'b0; b_pos = 0; end
    else if (!b_run) begin b_run = 1'b1; b_pos = 0; ld = frame_valid; end
    else if (b_pos == B_PER - 1) begin b_pos = 0; ld = frame_valid; end
    else b_pos++;
    if (ld) b_shadow = frame_data;
    if (b_track) q_b.push_back(model_out(b_run, b_pos, ld, b_shadow, B_DIV, B_BLANK));
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; frame_valid = 1'b0; frame_data = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL reset_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL reset_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (k == 3) rst_n = 1'b1;
    end
  endtask

  task automatic test_first_row();
    int first_drive = -1, n_a5 = 0, n_ack = 0;
    frame_data = make_frame(16'hA5A5); frame_valid = 1'b1; en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL first_row_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL first_row_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (a_row_sel == 12'h001 && a_col == 16'hA5A5) begin
        n_a5++;
        if (first_drive < 0) first_drive = k;
      end
      if (a_ack) n_ack++;
    end
    n_vec++; if (first_drive != 3) begin n_bad++; $display("FAIL first_row_start: got %0d want 3", first_drive); end
    n_vec++; if (n_a5 != A_DIV) begin n_bad++; $display("FAIL first_row_len: got %0d want %0d", n_a5, A_DIV); end
    n_vec++; if (n_ack != 1) begin n_bad++; $display("FAIL first_row_ack: got %0d want 1", n_ack); end
  endtask

  task automatic test_frame_wrap();
    int n_done = 0;
    bit prev_done = 1'b0;
    for (int k = 0; k < A_PER; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL wrap_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL wrap_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (prev_done) begin
        n_vec++;
        if (a_cur_row !== 4'd0) begin n_bad++; $display("FAIL wrap_row: got %0d want 0", a_cur_row); end
      end
      prev_done = a_done;
      if (a_done) begin
        n_done++; n_vec++;
        if (a_cur_row !== 4'd11 || a_row_sel !== 12'h800)
          begin n_bad++; $display("FAIL done_row: got row %0d sel %h want 11 800", a_cur_row, a_row_sel); end
      end
    end
    n_vec++; if (n_done != 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_no_tearing();
    bit armed = 1'b0, acked = 1'b0, fin = 1'b0;
    int tear = 0, last_row = -1;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL tear_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL tear_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (armed) begin
        if (a_ack) acked = 1'b1;
        if (!acked && a_row_sel != '0) begin
          last_row = int'(a_cur_row);
          if (a_col == 16'hFFFF) tear++;
        end
        if (acked && a_row_sel == 12'h001) begin
          n_vec++; fin = 1'b1;
          if (a_col !== 16'hFFFF) begin n_bad++; $display("FAIL new_frame_row0: got %h want ffff", a_col); end
        end
      end else if (a_cur_row == 4'd5) begin
        armed = 1'b1; frame_data = '1;
      end
    end
    n_vec++; if (!fin) begin n_bad++; $display("FAIL tear_timeout: got 0 want 1"); end
    n_vec++; if (tear != 0) begin n_bad++; $display("FAIL tearing: got %0d want 0", tear); end
    n_vec++; if (last_row != 11) begin n_bad++; $display("FAIL ack_point: got %0d want 11", last_row); end
  endtask

  task automatic test_no_valid();
    int n_ack = 0;
    frame_valid = 1'b0; frame_data = make_frame(16'h1234);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL novalid_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL novalid_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (a_ack) n_ack++;
      if (a_row_sel != '0) begin
        n_vec++;
        if (a_col !== 16'hFFFF) begin n_bad++; $display("FAIL repeat_frame: got %h want ffff", a_col); end
      end
    end
    n_vec++; if (n_ack != 0) begin n_bad++; $display("FAIL novalid_ack: got %0d want 0", n_ack); end
  endtask

  task automatic test_en_drop();
    int ph = 0, cnt = 0;
    for (int k = 0; k < 150 && ph < 4; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL endrop_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL endrop_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      case (ph)
        0: if (a_cur_row == 4'd7 && a_row_sel != '0) begin en = 1'b0; ph = 1; end
        1: begin
          n_vec++; ph = 2; cnt = 0;
          if (a_row_sel !== '0 || a_col !== '0 || a_cur_row !== 4'd0)
            begin n_bad++; $display("FAIL endrop_dark: got %h %h %0d want 0 0 0", a_row_sel, a_col, a_cur_row); end
        end
        2: begin cnt++; if (cnt == 2) begin en = 1'b1; ph = 3; cnt = 0; end end
        default: begin
          cnt++; n_vec++;
          if (cnt < 3) begin
            if (a_row_sel !== '0) begin n_bad++; $display("FAIL reen_blank: got %h want 000", a_row_sel); end
          end else begin
            ph = 4;
            if (a_row_sel !== 12'h001 || a_col !== 16'hFFFF)
              begin n_bad++; $display("FAIL reen_row0: got %h %h want 001 ffff", a_row_sel, a_col); end
          end
        end
      endcase
    end
    n_vec++; if (ph != 4) begin n_bad++; $display("FAIL endrop_timeout: got phase %0d want 4", ph); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int n_ack = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL rstmid_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL rstmid_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (a_row_sel != '0) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL rstmid_timeout: got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1 n_vec++;
    if (obs_a !== '0) begin n_bad++; $display("FAIL async_reset: got %h want 0", obs_a); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL rstmid_sb: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL rstmid_sb @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (k == 0) rst_n = 1'b1;
      if (a_ack) n_ack++;
      if (a_row_sel != '0) begin
        n_vec++;
        if (a_col !== 16'h0000) begin n_bad++; $display("FAIL shadow_cleared: got %h want 0000", a_col); end
      end
    end
    n_vec++; if (n_ack != 0) begin n_bad++; $display("FAIL rstmid_ack: got %0d want 0", n_ack); end
  endtask

  task automatic test_no_blank();
    int dark = 0;
    q_b.delete(); b_track = 1'b1;
    frame_valid = 1'b1; frame_data = make_frame(16'h0F0F);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (q_a.size() == 0) begin n_bad++; $display("FAIL noblank_sb_a: no expected entry @%0t", $time); end
      else begin
        exp_a = q_a.pop_front(); n_vec++;
        if (obs_a !== exp_a) begin n_bad++; $display("FAIL noblank_sb_a @%0t: got %h want %h", $time, obs_a, exp_a); end
      end
      if (q_b.size() == 0) begin n_bad++; $display("FAIL noblank_sb_b: no expected entry @%0t", $time); end
      else begin
        exp_b = q_b.pop_front(); n_vec++;
        if (obs_b !== exp_b) begin n_bad++; $display("FAIL noblank_sb_b @%0t: got %h want %h", $time, obs_b, exp_b); end
      end
      if (b_row_sel == '0) dark++;
      if (b_done) begin
        n_vec++;
        if (b_cur_row !== 4'd11 || b_row_sel !== 12'h800)
          begin n_bad++; $display("FAIL noblank_done: got row %0d sel %h want 11 800", b_cur_row, b_row_sel); end
      end
    end
    n_vec++; if (dark != 0) begin n_bad++; $display("FAIL noblank_dark: got %0d want 0", dark); end
    b_track = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_frame_wrap();
    test_no_tearing();
    test_no_valid();
    test_en_drop();
    test_reset_mid();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
